// File: rtl/scan_mux_pkg.sv
// Shared constants for the scan multiplexer: mode encoding.
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_rr_find.sv
// Rotating first-one search: lowest index at or above start (modulo N_CH) whose mask bit is set.
// Purely combinational, zero latency; no flow control.
module rr_find
  import scan_mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [SELW-1:0] start,
  output logic            found,
  output logic [SELW-1:0] idx
);

  // One extra bit so start+k cannot overflow before the modulo fold.
  logic [SELW:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, start} + (SELW+1)'(k);
      if (cand >= (SELW+1)'(N_CH)) begin
        cand = cand - (SELW+1)'(N_CH);
      end
      if (!found && mask[cand[SELW-1:0]]) begin
        found = 1'b1;
        idx   = cand[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Channel multiplexer with registered output, MANUAL select or masked round-robin SCAN.
// One-cycle latency; a beat is held stable while out_ready is low, otherwise reloads every cycle.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int DW   = 8,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N_CH-1:0]    mask,
  input  logic [N_CH*DW-1:0] din,
  output logic [DW-1:0]      out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  logic [DW-1:0]   ch_dat [N_CH];
  logic [SELW-1:0] scan_ptr, ptr_nxt;
  logic [SELW-1:0] hit_idx;
  logic            hit;
  logic            load;
  logic            sel_ok;
  logic [DW-1:0]   data_nxt;
  logic [SELW-1:0] ch_nxt;
  logic            valid_nxt;
  logic            err_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_dat[i] = din[i*DW +: DW];
  end

  rr_find #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_find (
    .mask  (mask),
    .start (scan_ptr),
    .found (hit),
    .idx   (hit_idx)
  );

  assign load   = !out_valid || out_ready;
  // Only meaningful when N_CH is not a power of two.
  assign sel_ok = ({1'b0, sel} < (SELW+1)'(N_CH));

  always_comb begin
    data_nxt  = out_data;
    ch_nxt    = out_ch;
    valid_nxt = out_valid;
    ptr_nxt   = scan_ptr;
    err_nxt   = 1'b0;
    if (load) begin
      if (!en) begin
        valid_nxt = 1'b0;
      end else if (mode == MODE_MANUAL) begin
        if (sel_ok) begin
          data_nxt  = ch_dat[sel];
          ch_nxt    = sel;
          valid_nxt = 1'b1;
        end else begin
          valid_nxt = 1'b0;
          err_nxt   = 1'b1;
        end
      end else if (hit) begin
        data_nxt  = ch_dat[hit_idx];
        ch_nxt    = hit_idx;
        valid_nxt = 1'b1;
        ptr_nxt   = (hit_idx == SELW'(N_CH-1)) ? '0 : hit_idx + SELW'(1);
      end else begin
        valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      scan_ptr  <= '0;
    end else begin
      out_data  <= data_nxt;
      out_ch    <= ch_nxt;
      out_valid <= valid_nxt;
      sel_err   <= err_nxt;
      scan_ptr  <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed scenarios plus randomized traffic against a behavioural model.
module tb_scan_mux;
  import scan_mux_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, mode, out_ready;
  logic [2:0]  sel, sel6;
  logic [7:0]  mask;
  logic [63:0] din;
  logic [47:0] din6;
  logic [7:0]  out_data, out_data6;
  logic [2:0]  out_ch, out_ch6;
  logic        out_valid, out_valid6, sel_err, sel_err6;

  always #5 clk = ~clk;

  scan_mux #(.N_CH(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .mask(mask), .din(din),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  scan_mux #(.N_CH(6), .DW(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(MODE_MANUAL), .sel(sel6), .mask(mask[5:0]),
    .din(din6), .out_data(out_data6), .out_ch(out_ch6), .out_valid(out_valid6),
    .out_ready(1'b1), .sel_err(sel_err6)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference state: the beat currently presented and the round-robin position.
  bit         m_v, m_err;
  int         m_ch, m_ptr;
  logic [7:0] m_d;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_err = 0; m_ch = 0; m_ptr = 0; m_d = '0;
  endtask

  task automatic model_step();
    bit found;
    int c;
    m_err = 0;
    if (!m_v || out_ready) begin
      if (!en) begin
        m_v = 0;
      end else if (mode == MODE_MANUAL) begin
        m_v  = 1;
        m_ch = int'(sel);
        m_d  = din[int'(sel)*8 +: 8];
      end else begin
        found = 0;
        c = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && mask[(m_ptr + k) % N]) begin
            found = 1;
            c = (m_ptr + k) % N;
          end
        end
        if (found) begin
          m_v   = 1;
          m_ch  = c;
          m_d   = din[c*8 +: 8];
          m_ptr = (c + 1) % N;
        end else begin
          m_v = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("valid", out_valid, m_v);
    chk("data", out_data, m_d);
    chk("ch", out_ch, m_ch);
    chk("sel_err", sel_err, m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic expect_beat(input string tag, input int c);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ch"}, out_ch, c);
    chk({tag, "_data"}, out_data, 8'h10 + c);
  endtask

  task automatic std_din();
    for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'h10 + i;
    for (int i = 0; i < 6; i++) din6[i*8 +: 8] = 8'h10 + i;
  endtask

  initial begin
    int pat [5];
    pat = '{2, 5, 7, 2, 5};
    en = 1'b1; mode = MODE_MANUAL; sel = '0; sel6 = '0; mask = 8'hFF; out_ready = 1'b1;
    std_din();
    model_reset();

    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_err", sel_err, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual sweep; the 6-channel instance sees one out-of-range select first.
    for (int i = 0; i < 8; i++) begin
      sel  = 3'(i);
      sel6 = (i == 0) ? 3'd7 : 3'd2;
      cycle();
      expect_beat("manual", i);
      if (i == 0) begin
        chk("err6_pulse", sel_err6, 1);
        chk("err6_valid", out_valid6, 0);
      end
      if (i == 1) begin
        chk("err6_clear", sel_err6, 0);
        chk("six_valid", out_valid6, 1);
        chk("six_ch", out_ch6, 2);
        chk("six_data", out_data6, 8'h12);
      end
    end

    mode = MODE_SCAN;
    for (int k = 0; k < 10; k++) begin
      cycle();
      expect_beat("scan_all", k % 8);
    end

    mask = 8'b1010_0100;
    for (int k = 0; k < 5; k++) begin
      cycle();
      expect_beat("scan_sparse", pat[k]);
    end
    mask = 8'h00;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("scan_none_valid", out_valid, 0);
    end
    mask = 8'hFF;
    cycle();
    expect_beat("scan_resume", 6);

    mask = 8'h08;
    for (int k = 0; k < 3; k++) begin
      cycle();
      expect_beat("scan_single", 3);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mode = ~mode;
      mask = 8'($urandom);
      din  = {$urandom, $urandom};
      cycle();
      expect_beat("hold", 3);
    end
    mode = MODE_SCAN; mask = 8'hFF; out_ready = 1'b1;
    std_din();
    cycle();
    expect_beat("after_hold", 4);

    // Reset lands mid-cycle with the scan pointer at 5.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ch", out_ch, 0);
    chk("arst_err", sel_err, 0);
    chk("arst_valid6", out_valid6, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    expect_beat("post_rst", 0);

    for (int k = 0; k < 400; k++) begin
      en   = ($urandom_range(0, 7) != 0);
      mode = 1'($urandom_range(0, 1));
      sel  = 3'($urandom);
      sel6 = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       mask = 8'h00;
        1:       mask = 8'(1 << $urandom_range(0, 7));
        default: mask = 8'($urandom);
      endcase
      din       = {$urandom, $urandom};
      din6      = 48'({$urandom, $urandom});
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter N_CH, default 8, number of input channels (2..64).
REQ-002 Parameter DW, default 8, data width per channel (1..64).
REQ-003 Parameter SELW, default $clog2(N_CH), channel-index width; derived, not overridden.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  global enable; when 0, no new beats are produced.
REQ-007 mode  input  1  0 = MANUAL (channel from sel), 1 = SCAN (internal round-robin).
REQ-008 sel  input  SELW  channel index used in MANUAL.
REQ-009 mask  input  N_CH  per-channel scan enable in SCAN (bit i = 1 means channel i is eligible); ignored in MANUAL.
REQ-010 din  input  N_CH*DW  packed channel data; channel i occupies bits [i*DW +: DW].
REQ-011 out_data  output  DW  registered selected data.
REQ-012 out_ch  output  SELW  index of the channel captured in out_data.
REQ-013 out_valid  output  1  out_data/out_ch hold a beat.
REQ-014 out_ready  input  1  downstream accepts the beat.
REQ-015 sel_err  output  1  one-cycle pulse when MANUAL sel >= N_CH at a load opportunity.

Function
REQ-016 A transfer occurs in a cycle where out_valid = 1 and out_ready = 1.
REQ-017 A load opportunity exists in a cycle where out_valid = 0 or out_ready = 1.
REQ-018 While out_valid = 1 and out_ready = 0, out_data, out_ch and out_valid remain stable regardless of en, mode, sel, mask or din.
REQ-019 At a load opportunity with en = 0, out_valid becomes 0 on the next edge.
REQ-020 MANUAL load with sel < N_CH: out_data <= din[sel], out_ch <= sel, out_valid <= 1 on the next edge (one-cycle latency).
REQ-021 MANUAL load with sel >= N_CH: out_valid <= 0, sel_err pulses high for exactly one cycle, and no data is captured.
REQ-022 SCAN load: the chosen channel c is the first channel with mask = 1 found by searching from scan_ptr upward with wrap-around modulo N_CH; out_data <= din[c], out_ch <= c, out_valid <= 1, and scan_ptr <= (c+1) mod N_CH.
REQ-023 SCAN load with mask = 0: out_valid <= 0 and scan_ptr is unchanged.
REQ-024 scan_ptr wraps from N_CH-1 to 0; with one eligible channel, every SCAN beat selects that channel.
REQ-025 scan_ptr changes only on a SCAN load; a switch to MANUAL and back resumes from the retained scan_ptr.
REQ-026 A mode or mask change takes effect at the next load opportunity and never alters a held beat.
REQ-027 Back-to-back transfers are supported: with en = 1 and out_ready held at 1, one beat is produced per cycle.

Reset
REQ-028 While rst_n = 0: out_data = 0, out_ch = 0, out_valid = 0, sel_err = 0, scan_ptr = 0, all applied asynchronously.
REQ-029 Reset asserted mid-beat discards the held beat; the first load after rst_n deasserts starts from scan_ptr = 0.

Structure
REQ-030 The shared package scan_mux_pkg holds the mode encoding constants MODE_MANUAL = 0 and MODE_SCAN = 1.
REQ-031 The rotating first-one search is a sub-module, rr_find (inputs: mask, start index; outputs: found flag, index), and is purely combinational.
REQ-032 scan_mux contains only the output register, scan_ptr and the load/handshake control.

Verification (N_CH = 8, DW = 8, din channel i = 8'h10+i)
REQ-033 MANUAL: en = 1, out_ready = 1, sel sweeps 0..7 -> out_data 8'h10..8'h17 with out_ch 0..7, each one cycle after its sel.
REQ-034 SCAN: mask = 8'hFF, out_ready = 1 for 10 cycles -> out_ch 0,1,...,7,0,1.
REQ-035 SCAN: mask = 8'b1010_0100, out_ready = 1 -> out_ch 2,5,7,2,5; with mask = 0, out_valid stays 0 and scan_ptr is unchanged.
REQ-036 Backpressure: beat at out_ch 3, out_ready = 0 for 4 cycles while mode, mask and din toggle -> beat is held unchanged; next out_ch is 4 after out_ready = 1.
REQ-037 Error and reset: MANUAL, N_CH = 6, sel = 7 -> sel_err pulses once and out_valid = 0; rst_n low mid-SCAN at scan_ptr = 5 -> all outputs 0 immediately and the next SCAN beat has out_ch = 0.
